// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM radio datapath: fixed-point scaling,
// quantized angle constants, the DEQ helper and the demod FSM state type.
package fm_radio_pkg;

  localparam int QUANT_BITS = 10;
  localparam int QUAD1      = 804;   // pi/4 in QUANT_BITS fixed point
  localparam int QUAD3      = 2412;  // 3*pi/4 in QUANT_BITS fixed point

  // Added to negative values before the arithmetic shift so DEQ truncates toward zero
  localparam logic signed [63:0] DEQ_BIAS = (64'sd1 <<< QUANT_BITS) - 64'sd1;

  typedef enum logic [2:0] {
    READ,
    CONJ,
    PREP,
    DIV,
    ANGLE,
    SCALE,
    WRITE
  } fm_demod_state_t;

  // Signed x / 2**QUANT_BITS, truncating toward zero
  function automatic logic signed [63:0] deq(input logic signed [63:0] x);
    logic signed [63:0] biased;
    biased = x[63] ? (x + DEQ_BIAS) : x;
    return biased >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/fm_demod_div_seq_signed.sv
// Sequential signed divider: restoring core on magnitudes, one quotient bit
// per clock, DATA_WIDTH iterations after start. done is high during the
// final iteration cycle; quotient is valid from the following cycle on.
module div_seq_signed #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] dividend,
  input  logic signed [DATA_WIDTH-1:0] divisor,
  output logic signed [DATA_WIDTH-1:0] quotient,
  output logic                         done
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] quo_mag;
  logic [DW-1:0] dvs_mag;
  logic [DW-1:0] rem;
  logic          neg;
  logic [DW:0]   rem_shift;
  logic [DW:0]   diff;
  logic          fits;

  function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] x);
    return x[DW-1] ? -x : x;
  endfunction

  // Iteration counter; reset aborts any division in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(DATA_WIDTH);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Trial subtraction of the divisor from the partial remainder
  always_comb begin
    rem_shift = {rem, quo_mag[DW-1]};
    diff      = rem_shift - {1'b0, dvs_mag};
    fits      = !diff[DW];
  end

  // Dividend magnitude shifts out of quo_mag as quotient bits shift in
  always_ff @(posedge clock) begin
    if (start) begin
      quo_mag <= mag(dividend);
      dvs_mag <= mag(divisor);
      rem     <= '0;
      neg     <= dividend[DW-1] ^ divisor[DW-1];
    end else if (cnt != '0) begin
      rem     <= fits ? diff[DW-1:0] : rem_shift[DW-1:0];
      quo_mag <= {quo_mag[DW-2:0], fits};
    end
  end

  assign quotient = neg ? -$signed(quo_mag) : $signed(quo_mag);
  assign done     = (cnt == CW'(1));

endmodule

// File: rtl/fm_demod.sv
// FM discriminator: conjugate product with the previous I/Q sample, quantized
// arctan via a ratio division, demod gain, one output sample per input.
// Build option FM_DEMOD_SATURATE_EN clamps the output to [-32767, 32767].
import fm_radio_pkg::*;

module fm_demod #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN       = 758
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic signed [DATA_WIDTH-1:0] out_dout
);

  localparam int DW = DATA_WIDTH;
  localparam logic signed [DW-1:0] QUAD1_W = DW'(QUAD1);
  localparam logic signed [DW-1:0] QUAD3_W = DW'(QUAD3);
  localparam logic signed [DW-1:0] GAIN_W  = DW'(GAIN);

  fm_demod_state_t state, state_next;

  logic signed [DW-1:0] i_p0, q_p0;
  logic signed [DW-1:0] prev_i, prev_q;
  logic signed [DW-1:0] re_p1, im_p1;
  logic signed [DW-1:0] base_p2;
  logic signed [DW-1:0] ang_p3;

  logic signed [DW-1:0] re_c, im_c, ay_c, num_c, den_c, base_c, ang_c, scale_c;
  logic signed [DW-1:0] quot;
  logic                 accept;
  logic                 div_start;
  logic                 div_done;

  function automatic logic signed [DW-1:0] deq_w(input logic signed [DW-1:0] x);
    return DW'(deq(64'(x)));
  endfunction

`ifdef FM_DEMOD_SATURATE_EN
  localparam logic signed [DW-1:0] SAT_MAX = DW'(32767);
  localparam logic signed [DW-1:0] SAT_MIN = DW'(-32767);

  function automatic logic signed [DW-1:0] sat_out(input logic signed [DW-1:0] x);
    if (x > SAT_MAX) return SAT_MAX;
    if (x < SAT_MIN) return SAT_MIN;
    return x;
  endfunction
`endif

  // State register; reset returns to READ and abandons any in-flight sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= READ;
    else       state <= state_next;
  end

  // Next-state and FIFO handshakes; reads and writes live in disjoint states
  always_comb begin
    state_next = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    div_start  = 1'b0;
    accept     = 1'b0;
    case (state)
      READ: begin
        in_rd_en = !reset;
        accept   = !reset && !in_empty;
        if (accept) state_next = CONJ;
      end
      CONJ:  state_next = PREP;
      PREP: begin
        div_start  = 1'b1;
        state_next = DIV;
      end
      DIV:   if (div_done) state_next = ANGLE;
      ANGLE: state_next = SCALE;
      SCALE: state_next = WRITE;
      WRITE: begin
        out_wr_en = !out_full;
        if (!out_full) state_next = READ;
      end
      default: state_next = READ;
    endcase
  end

  // Datapath arithmetic for every stage, all DW wide with wraparound
  always_comb begin
    re_c = deq_w(prev_i * i_p0) + deq_w(prev_q * q_p0);
    im_c = deq_w(prev_i * q_p0) - deq_w(prev_q * i_p0);

    ay_c = (im_p1[DW-1] ? -im_p1 : im_p1) + DW'(1);
    if (!re_p1[DW-1]) begin
      num_c  = (re_p1 - ay_c) <<< QUANT_BITS;
      den_c  = re_p1 + ay_c;
      base_c = QUAD1_W;
    end else begin
      num_c  = (re_p1 + ay_c) <<< QUANT_BITS;
      den_c  = ay_c - re_p1;
      base_c = QUAD3_W;
    end

    ang_c = base_p2 - deq_w(QUAD1_W * quot);
    if (im_p1[DW-1]) ang_c = -ang_c;

`ifdef FM_DEMOD_SATURATE_EN
    scale_c = sat_out(deq_w(GAIN_W * ang_p3));
`else
    scale_c = deq_w(GAIN_W * ang_p3);
`endif
  end

  // Stage registers without reset: each loads only in its own state
  always_ff @(posedge clock) begin
    // p0: accepted input sample
    if (accept) begin
      i_p0 <= in_i;
      q_p0 <= in_q;
    end
    // p1: conjugate product
    if (state == CONJ) begin
      re_p1 <= re_c;
      im_p1 <= im_c;
    end
    // p2: quadrant base angle
    if (state == PREP) base_p2 <= base_c;
    // p3: signed angle
    if (state == ANGLE) ang_p3 <= ang_c;
  end

  // Previous-sample history and output register, cleared on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_i   <= '0;
      prev_q   <= '0;
      out_dout <= '0;
    end else begin
      if (state == CONJ) begin
        prev_i <= i_p0;
        prev_q <= q_p0;
      end
      if (state == SCALE) out_dout <= scale_c;
    end
  end

  div_seq_signed #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (num_c),
    .divisor  (den_c),
    .quotient (quot),
    .done     (div_done)
  );

endmodule
